control_captura: RTL and testbench

- Sequencing controller between the keypad scanner (`teclado`) and the multiplexed display (`display_7seg`).
- Turns one-cycle key events into a 4-digit hexadecimal entry buffer with backspace, clear and enter editing.
- Drives the display digit word and per-digit enables.
- On enter, latches the entered value, issues a one-cycle strobe, then holds the value on screen for a fixed time before clearing.

---
 rtl/control_captura.sv | 140 ++++++++++++++
 tb/tb_control_captura.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/control_captura.sv
// Keypad-to-display entry controller: 4-digit hex buffer with backspace/clear/enter and timed confirm hold.
// Optional CTRL_AUTOENTER_EN: the 4th digit confirms immediately instead of waiting for ENTER.
module control_captura #(
    parameter int HOLD_CYC = 13500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tecla_valida,
    input  logic [3:0]  tecla,
    output logic [15:0] digitos,
    output logic [3:0]  en_digito,
    output logic [2:0]  num_dig,
    output logic [15:0] dato,
    output logic        dato_listo,
    output logic        rechazo
);

    localparam int TW = $clog2(HOLD_CYC);
    localparam logic [TW-1:0] HOLD_M1 = TW'(HOLD_CYC - 1);

    localparam logic [3:0] K_ENTER  = 4'hA;
    localparam logic [3:0] K_BORRA  = 4'hB;
    localparam logic [3:0] K_LIMPIA = 4'hC;

    typedef enum logic [1:0] {VACIO, CAPTURA, LLENO, CONFIRMA} estado_t;

    estado_t        state, state_n;
    logic [15:0]    digitos_n, dato_n;
    logic [3:0]     en_n;
    logic [2:0]     num_n;
    logic           listo_n, rech_n;
    logic [TW-1:0]  timer, timer_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= VACIO;
            digitos    <= '0;
            en_digito  <= '0;
            num_dig    <= '0;
            dato       <= '0;
            dato_listo <= 1'b0;
            rechazo    <= 1'b0;
            timer      <= '0;
        end else begin
            state      <= state_n;
            digitos    <= digitos_n;
            en_digito  <= en_n;
            num_dig    <= num_n;
            dato       <= dato_n;
            dato_listo <= listo_n;
            rechazo    <= rech_n;
            timer      <= timer_n;
        end
    end

    always_comb begin
        state_n   = state;
        digitos_n = digitos;
        num_n     = num_dig;
        dato_n    = dato;
        listo_n   = 1'b0;
        rech_n    = 1'b0;
        timer_n   = timer;
        en_n      = 4'b0000;

        if (state == CONFIRMA) begin
            // Keys are swallowed while the confirmed value is on screen.
            if (timer == '0) begin
                state_n   = VACIO;
                digitos_n = '0;
                num_n     = '0;
            end else begin
                timer_n = timer - TW'(1);
            end
        end else if (tecla_valida) begin
            if (tecla <= 4'h9) begin
                if (state != LLENO) begin
                    digitos_n = {digitos[11:0], tecla};
                    num_n     = num_dig + 3'd1;
                    if (num_dig == 3'd3) begin
`ifdef CTRL_AUTOENTER_EN
                        dato_n  = {digitos[11:0], tecla};
                        listo_n = 1'b1;
                        timer_n = HOLD_M1;
                        state_n = CONFIRMA;
`else
                        state_n = LLENO;
`endif
                    end else begin
                        state_n = CAPTURA;
                    end
                end else begin
                    rech_n = 1'b1;
                end
            end else begin
                case (tecla)
                    K_ENTER: begin
                        if (state != VACIO) begin
                            dato_n  = digitos;
                            listo_n = 1'b1;
                            timer_n = HOLD_M1;
                            state_n = CONFIRMA;
                        end else begin
                            rech_n = 1'b1;
                        end
                    end
                    K_BORRA: begin
                        if (state != VACIO) begin
                            digitos_n = {4'h0, digitos[15:4]};
                            num_n     = num_dig - 3'd1;
                            state_n   = (num_dig == 3'd1) ? VACIO : CAPTURA;
                        end else begin
                            rech_n = 1'b1;
                        end
                    end
                    K_LIMPIA: begin
                        digitos_n = '0;
                        num_n     = '0;
                        state_n   = VACIO;
                    end
                    default: ;
                endcase
            end
        end

        // Enables follow the registered count, right-justified, or all-on while confirming.
        if (state_n == CONFIRMA) begin
            en_n = 4'b1111;
        end else begin
            case (num_n)
                3'd0:    en_n = 4'b0000;
                3'd1:    en_n = 4'b0001;
                3'd2:    en_n = 4'b0011;
                3'd3:    en_n = 4'b0111;
                default: en_n = 4'b1111;
            endcase
        end
    end

endmodule

// File: tb/tb_control_captura.sv
// Self-checking bench for control_captura: directed sequences plus random keys against a queue-based model.
module tb_control_captura;

   localparam int HOLD = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tecla_valida = 1'b0;
   logic [3:0]  tecla = 4'h0;
   logic [15:0] digitos;
   logic [3:0]  en_digito;
   logic [2:0]  num_dig;
   logic [15:0] dato;
   logic        dato_listo;
   logic        rechazo;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: entered digits oldest-first, confirmed value, remaining hold cycles.
   int          q[$];
   logic [15:0] m_dato;
   logic        m_listo, m_rech, conf;
   int          left;

   control_captura #(.HOLD_CYC(HOLD)) dut (
      .clk(clk), .rst(rst), .tecla_valida(tecla_valida), .tecla(tecla),
      .digitos(digitos), .en_digito(en_digito), .num_dig(num_dig),
      .dato(dato), .dato_listo(dato_listo), .rechazo(rechazo)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] word();
      logic [15:0] w = 16'h0;
      foreach (q[i]) w = {w[11:0], 4'(q[i])};
      return w;
   endfunction

   task automatic modelReset();
      q.delete();
      m_dato = 16'h0; m_listo = 1'b0; m_rech = 1'b0; conf = 1'b0; left = 0;
   endtask

   task automatic modelEnter();
      m_dato = word(); m_listo = 1'b1; conf = 1'b1; left = HOLD;
   endtask

   task automatic modelStep(input logic v, input logic [3:0] k);
      m_listo = 1'b0; m_rech = 1'b0;
      if (conf) begin
         left--;
         if (left == 0) begin conf = 1'b0; q.delete(); end
      end else if (v) begin
         if (k <= 4'h9) begin
            if (q.size() < 4) begin
               q.push_back(int'(k));
`ifdef CTRL_AUTOENTER_EN
               if (q.size() == 4) modelEnter();
`endif
            end else m_rech = 1'b1;
         end else if (k == 4'hA) begin
            if (q.size() > 0) modelEnter(); else m_rech = 1'b1;
         end else if (k == 4'hB) begin
            if (q.size() > 0) void'(q.pop_back()); else m_rech = 1'b1;
         end else if (k == 4'hC) begin
            q.delete();
         end
      end
   endtask

   task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      logic [3:0] e_en;
      e_en = conf ? 4'hF : 4'((1 << q.size()) - 1);
      cmp("digitos", digitos, word());
      cmp("en_digito", 16'(en_digito), 16'(e_en));
      cmp("num_dig", 16'(num_dig), 16'(q.size()));
      cmp("dato", dato, m_dato);
      cmp("dato_listo", 16'(dato_listo), 16'(m_listo));
      cmp("rechazo", 16'(rechazo), 16'(m_rech));
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] k);
      @(negedge clk);
      tecla_valida = v;
      tecla = k;
      @(posedge clk);
      modelStep(v, k);
      #1 checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'(i));
   endtask

   initial begin
      modelReset();
      repeat (3) @(posedge clk);
      #1 checkOutput();
      @(negedge clk) rst = 1'b1;

      // Entry and enter, then the full hold period.
      applyStimulus(1, 4'h1);
      applyStimulus(1, 4'h2);
      applyStimulus(1, 4'h3);
      cmp("digitos_123", digitos, 16'h0123);
      cmp("en_123", 16'(en_digito), 16'h0007);
      applyStimulus(1, 4'hA);
      cmp("dato_123", dato, 16'h0123);
      cmp("listo_123", 16'(dato_listo), 16'h0001);
      idle(HOLD - 1);
      cmp("still_shown", digitos, 16'h0123);
      idle(1);
      cmp("cleared", digitos, 16'h0000);
      cmp("cleared_num", 16'(num_dig), 16'h0000);

      // Overflow: fifth digit rejected.
      applyStimulus(1, 4'h9);
      applyStimulus(1, 4'h8);
      applyStimulus(1, 4'h7);
      applyStimulus(1, 4'h6);
`ifndef CTRL_AUTOENTER_EN
      cmp("full_word", digitos, 16'h9876);
      applyStimulus(1, 4'h5);
      cmp("full_rech", 16'(rechazo), 16'h0001);
      applyStimulus(1, 4'hC);
`else
      cmp("auto_dato", dato, 16'h9876);
      cmp("auto_listo", 16'(dato_listo), 16'h0001);
      idle(HOLD);
`endif

      // Backspace down to empty, then underflow and empty enter.
      applyStimulus(1, 4'h4);
      applyStimulus(1, 4'h5);
      applyStimulus(1, 4'hB);
      cmp("borra_1", digitos, 16'h0004);
      applyStimulus(1, 4'hB);
      applyStimulus(1, 4'hB);
      cmp("borra_rech", 16'(rechazo), 16'h0001);
      applyStimulus(1, 4'hA);
      cmp("enter_empty_rech", 16'(rechazo), 16'h0001);

      // Back-to-back keys, clear, and an ignored code.
      applyStimulus(1, 4'h1);
      applyStimulus(1, 4'h2);
      cmp("b2b", digitos, 16'h0012);
      applyStimulus(1, 4'hC);
      applyStimulus(1, 4'hC);
      applyStimulus(1, 4'hE);
      cmp("ignored_rech", 16'(rechazo), 16'h0000);

      // Key during confirm is ignored; reset mid-confirm aborts at once.
      applyStimulus(1, 4'h7);
      applyStimulus(1, 4'hA);
      applyStimulus(1, 4'h3);
      cmp("confirm_ignores", digitos, 16'h0007);
      idle(2);
      #2 rst = 1'b0;
      modelReset();
      #1 checkOutput();
      @(negedge clk) rst = 1'b1;
      applyStimulus(1, 4'h5);
      cmp("after_reset", digitos, 16'h0005);

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         applyStimulus(($urandom % 3) != 0, 4'($urandom % 16));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
